// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage forwarding control: mux select codes,
// tag flag layout and the forwarding priority helper.
package fwd_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_RSV = 2'b11;

  // Tag payload layout, low bits first: {.., rd, memread, regwrite}
  localparam int TAG_FLAGS_W = 2;
  localparam int FLAG_RW     = 0;
  localparam int FLAG_MR     = 1;

  // MEM beats WB; an empty EX slot never forwards.
  function automatic logic [1:0] fwd_pick(input logic ex_valid,
                                          input logic mem_hit,
                                          input logic wb_hit);
    if (!ex_valid)    return FWD_REG;
    else if (mem_hit) return FWD_MEM;
    else if (wb_hit)  return FWD_WB;
    else              return FWD_REG;
  endfunction

endpackage

// File: rtl/fwd_tag_stage.sv
// One pipeline tag register: loads the incoming tag or captures a bubble.
// Reset and bubble both clear valid, flags and register indices.
module fwd_tag_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         d_valid_i,
  input  logic [W-1:0] d_data_i,
  output logic         q_valid_o,
  output logic [W-1:0] q_data_o
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load_i) begin
      r_valid <= d_valid_i;
      r_data  <= d_data_i;
    end else begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end
  end

  assign q_valid_o = r_valid;
  assign q_data_o  = r_data;

endmodule

// File: rtl/fwd_ctrl_unit.sv
// EX-stage operand forwarding control: tracks EX/MEM/WB tags, drives the
// operand mux selects and raises a one-cycle load-use stall.
module fwd_ctrl_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // EX keeps sources too; MEM/WB keep only {rd, regwrite} since load-use
  // detection looks at EX alone and nothing downstream needs memread.
  localparam int EXW = 3*REG_AW + TAG_FLAGS_W;
  localparam int PW  = REG_AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              w_ex_load, w_stall, w_hazard;
  logic [EXW-1:0]    w_id_data, w_ex_data;
  logic [PW-1:0]     w_mem_in, w_mem_data, w_wb_data;
  logic              w_ex_valid, w_mem_valid, w_wb_valid;
  logic [REG_AW-1:0] w_ex_rd, w_ex_rs1, w_ex_rs2, w_mem_rd, w_wb_rd;
  logic              w_ex_mr, w_ex_rw, w_mem_rw, w_wb_rw;
  logic              w_mem_ok, w_wb_ok;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_id_data = {id_rs2_i, id_rs1_i, id_rd_i, id_memread_i, id_regwrite_i};
  assign w_ex_load = id_valid_i && !w_stall && !flush_i;

  fwd_tag_stage #(.W(EXW)) u_ex (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (w_ex_load),
    .d_valid_i (id_valid_i),
    .d_data_i  (w_id_data),
    .q_valid_o (w_ex_valid),
    .q_data_o  (w_ex_data)
  );

  assign w_ex_rw  = w_ex_data[FLAG_RW];
  assign w_ex_mr  = w_ex_data[FLAG_MR];
  assign w_ex_rd  = w_ex_data[TAG_FLAGS_W +: REG_AW];
  assign w_ex_rs1 = w_ex_data[TAG_FLAGS_W + REG_AW +: REG_AW];
  assign w_ex_rs2 = w_ex_data[TAG_FLAGS_W + 2*REG_AW +: REG_AW];
  assign w_mem_in = {w_ex_rd, w_ex_rw};

  fwd_tag_stage #(.W(PW)) u_mem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (1'b1),
    .d_valid_i (w_ex_valid),
    .d_data_i  (w_mem_in),
    .q_valid_o (w_mem_valid),
    .q_data_o  (w_mem_data)
  );

  fwd_tag_stage #(.W(PW)) u_wb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (1'b1),
    .d_valid_i (w_mem_valid),
    .d_data_i  (w_mem_data),
    .q_valid_o (w_wb_valid),
    .q_data_o  (w_wb_data)
  );

  assign w_mem_rw = w_mem_data[0];
  assign w_mem_rd = w_mem_data[PW-1:1];
  assign w_wb_rw  = w_wb_data[0];
  assign w_wb_rd  = w_wb_data[PW-1:1];

  // x0 is hardwired, so a producer targeting it never forwards.
  assign w_mem_ok = w_mem_valid && w_mem_rw && (w_mem_rd != '0);
  assign w_wb_ok  = w_wb_valid  && w_wb_rw  && (w_wb_rd  != '0);

  assign fwd_a_o = fwd_pick(w_ex_valid, w_mem_ok && (w_mem_rd == w_ex_rs1),
                            w_wb_ok && (w_wb_rd == w_ex_rs1));
  assign fwd_b_o = fwd_pick(w_ex_valid, w_mem_ok && (w_mem_rd == w_ex_rs2),
                            w_wb_ok && (w_wb_rd == w_ex_rs2));

  assign w_hazard = id_valid_i && w_ex_valid && w_ex_mr && (w_ex_rd != '0) &&
                    ((w_ex_rd == id_rs1_i) || (w_ex_rd == id_rs2_i));
  // Flush wins over a hazard; ID is ignored while in reset.
  assign w_stall  = w_hazard && !flush_i && !rst_i;
  assign stall_o  = w_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != CNT_MAX))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Bench for fwd_ctrl_unit: directed vector table, load-use/saturation
// sequences and randomized traffic against a behavioural model.
module tb_fwd_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       idv, idrw, idmr, flush;
  logic [4:0] rs1, rs2, rd;
  logic [1:0] fa, fb, fa4, fb4;
  logic       st, st4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  fwd_ctrl_unit #(.REG_AW(5), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(idv), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rd_i(rd), .id_regwrite_i(idrw), .id_memread_i(idmr), .flush_i(flush),
    .fwd_a_o(fa), .fwd_b_o(fb), .stall_o(st), .stall_cnt_o(cnt)
  );

  fwd_ctrl_unit #(.REG_AW(5), .CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(idv), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rd_i(rd), .id_regwrite_i(idrw), .id_memread_i(idmr), .flush_i(flush),
    .fwd_a_o(fa4), .fwd_b_o(fb4), .stall_o(st4), .stall_cnt_o(cnt4)
  );

  int total = 0;
  int bad   = 0;

  // Model: the last three issued slots, youngest first (EX, MEM, WB).
  typedef struct { bit v; int rd; int s1; int s2; bit rw; bit mr; } slot_t;
  slot_t hist[3];
  int    m_cnt;

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 0; s.rd = 0; s.s1 = 0; s.s2 = 0; s.rw = 0; s.mr = 0;
    return s;
  endfunction

  // Nearest older producer of src wins: distance 1 -> MEM (2), distance 2 -> WB (1).
  function automatic int m_sel(int src);
    if (!hist[0].v) return 0;
    for (int d = 1; d <= 2; d++)
      if (hist[d].v && hist[d].rw && hist[d].rd != 0 && hist[d].rd == src)
        return (d == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    return !rst && !flush && idv && hist[0].v && hist[0].mr && hist[0].rd != 0 &&
           (hist[0].rd == int'(rs1) || hist[0].rd == int'(rs2));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int s1, input int s2, input int d,
                       input bit w, input bit m, input bit f, input bit r);
    idv = v; rs1 = 5'(s1); rs2 = 5'(s2); rd = 5'(d);
    idrw = w; idmr = m; flush = f; rst = r;
  endtask

  // Check outputs mid-cycle, then clock once and advance the model.
  task automatic cycle(input string nm, input int ea, input int eb, input int est, input int ecnt);
    bit    s;
    slot_t n;
    @(negedge clk);
    chk({nm, ".fwd_a"}, int'(fa), ea);
    chk({nm, ".fwd_b"}, int'(fb), eb);
    chk({nm, ".stall"}, int'(st), est);
    chk({nm, ".cnt"},   int'(cnt), ecnt);
    chk({nm, ".cnt4"},  int'(cnt4), (ecnt > 15) ? 15 : ecnt);
    s = m_stall();
    n.v = idv; n.rd = rd; n.s1 = rs1; n.s2 = rs2; n.rw = idrw; n.mr = idmr;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = empty_slot();
      m_cnt = 0;
    end else begin
      if (s) m_cnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (idv && !s && !flush) ? n : empty_slot();
    end
    #1;
  endtask

  task automatic mcycle(input string nm);
    cycle(nm, m_sel(hist[0].s1), m_sel(hist[0].s2), int'(m_stall()), m_cnt);
  endtask

  typedef struct {
    bit v; int s1; int s2; int d; bit w; bit m; bit f; bit r;
    int ea; int eb; int est; int ecnt;
  } vec_t;

  function automatic vec_t V(bit v, int s1, int s2, int d, bit w, bit m, bit f, bit r,
                             int ea, int eb, int est, int ecnt);
    vec_t t;
    t.v = v; t.s1 = s1; t.s2 = s2; t.d = d; t.w = w; t.m = m; t.f = f; t.r = r;
    t.ea = ea; t.eb = eb; t.est = est; t.ecnt = ecnt;
    return t;
  endfunction

  vec_t tbl[28];

  initial begin
    //              v s1 s2 d  w m f r   a b st cnt
    tbl[0]  = V(1, 1, 2, 5, 1,0,0,0, 0,0,0,0); // add x5
    tbl[1]  = V(1, 5, 1, 6, 1,0,0,0, 0,0,0,0); // add x6,x5,x1
    tbl[2]  = V(0, 0, 0, 0, 0,0,0,0, 2,0,0,0); // MEM forward on A
    tbl[3]  = V(0, 0, 0, 0, 0,0,0,0, 0,0,0,0);
    tbl[4]  = V(1, 1, 2, 5, 1,0,0,0, 0,0,0,0); // add x5
    tbl[5]  = V(0, 0, 0, 0, 0,0,0,0, 0,0,0,0); // nop
    tbl[6]  = V(1, 1, 5, 7, 1,0,0,0, 0,0,0,0); // sub x7,x1,x5
    tbl[7]  = V(0, 0, 0, 0, 0,0,0,0, 0,1,0,0); // WB forward on B
    tbl[8]  = V(1, 1, 2, 5, 1,0,0,0, 0,0,0,0); // add x5
    tbl[9]  = V(1, 1, 2, 5, 1,0,0,0, 0,0,0,0); // add x5
    tbl[10] = V(1, 5, 5, 8, 1,0,0,0, 0,0,0,0); // or x8,x5,x5
    tbl[11] = V(0, 0, 0, 0, 0,0,0,0, 2,2,0,0); // MEM beats WB
    tbl[12] = V(1, 1, 0, 9, 1,1,0,0, 0,0,0,0); // lw x9
    tbl[13] = V(1, 9, 2,10, 1,0,0,0, 0,0,1,0); // add x10,x9,x2 -> stall
    tbl[14] = V(1, 9, 2,10, 1,0,0,0, 0,0,0,1); // held, bubble in EX
    tbl[15] = V(0, 0, 0, 0, 0,0,0,0, 1,0,0,1); // load in WB forwards
    tbl[16] = V(1, 1, 2, 0, 1,0,0,0, 0,0,0,1); // add x0
    tbl[17] = V(1, 0, 0, 3, 1,0,0,0, 0,0,0,1); // add x3,x0,x0
    tbl[18] = V(1, 1, 0, 0, 1,1,0,0, 0,0,0,1); // lw x0
    tbl[19] = V(1, 0, 0, 4, 1,0,0,0, 0,0,0,1); // use x0: no stall
    tbl[20] = V(0, 0, 0, 0, 0,0,0,0, 0,0,0,1);
    tbl[21] = V(1, 1, 0, 9, 1,1,0,0, 0,0,0,1); // lw x9
    tbl[22] = V(1, 9, 2,10, 1,0,1,0, 0,0,0,1); // hazard + flush
    tbl[23] = V(0, 0, 0, 0, 0,0,0,0, 0,0,0,1); // bubble in EX
    tbl[24] = V(1, 1, 0, 9, 1,1,0,0, 0,0,0,1); // lw x9
    tbl[25] = V(1, 9, 2,10, 1,0,0,1, 0,0,0,1); // reset during hazard
    tbl[26] = V(1, 9, 2,10, 1,0,0,0, 0,0,0,0); // all cleared
    tbl[27] = V(0, 0, 0, 0, 0,0,0,0, 0,0,0,0);

    for (int i = 0; i < 3; i++) hist[i] = empty_slot();
    m_cnt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("reset", 0, 0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].w, tbl[i].m, tbl[i].f, tbl[i].r);
      cycle($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].est, tbl[i].ecnt);
    end

    // Repeated load-use pairs push the 4-bit counter into saturation.
    for (int k = 0; k < 18; k++) begin
      drive(1, 1, 0, 9, 1, 1, 0, 0);  mcycle("sat.lw");
      drive(1, 2, 9, 10, 1, 0, 0, 0); mcycle("sat.use");
      mcycle("sat.held");
    end
    chk("sat.cnt16", int'(cnt), 18);
    chk("sat.cnt4", int'(cnt4), 15);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, $urandom % 4, $urandom % 4, $urandom % 4,
            $urandom % 2, $urandom % 2, ($urandom % 10) == 0, ($urandom % 60) == 0);
      mcycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
